multdiv_unit: RTL and testbench



---
 rtl/multdiv_unit_pkg.sv | 23 ++
 rtl/multdiv_unit_add_sub_33.sv | 12 +
 rtl/multdiv_unit.sv | 144 ++++++++++++++
 tb/tb_multdiv_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_unit_pkg.sv
// Shared execute-stage definitions: datapath width, FSM state and op-type encodings,
// and the magnitude helper used when operands are latched.
package multdiv_unit_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  // 0x80000000 maps to itself, read back as the unsigned value 2^31.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/multdiv_unit_add_sub_33.sv
// 33-bit adder/subtractor shared by the multiply accumulate, the divide steps
// and the final sign negation.
module add_sub_33 (
  input  logic [32:0] a_i,
  input  logic [32:0] b_i,
  input  logic        sub_i,
  output logic [32:0] y_o
);

  assign y_o = a_i + (b_i ^ {33{sub_i}}) + {32'd0, sub_i};

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (shift-add) / divide (non-restoring) unit with a
// fixed 32-iteration latency; the sign fix-up is folded into the final iteration.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = multdiv_unit_pkg::WIDTH,
  parameter int ITER  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;

  logic             start;
  logic [WIDTH:0]   add_a, add_b, add_y, neg_y, mul_sum, step_hi;
  logic             add_sub;
  logic [WIDTH-1:0] step_lo;
  logic             mul_ovf, div_ovf;
  logic             unused_neg_msb;

  assign start = ctrl_MULT | ctrl_DIV;

  // hi holds the accumulator (multiply) or the signed partial remainder (divide);
  // lo holds the shifting multiplier or the dividend bits turning into quotient bits.
  assign add_a   = (op_q == OP_DIV) ? {hi_q[WIDTH-1:0], lo_q[WIDTH-1]} : hi_q;
  assign add_b   = {1'b0, b_q};
  assign add_sub = (op_q == OP_DIV) & ~hi_q[WIDTH];

  add_sub_33 u_step (
    .a_i   (add_a),
    .b_i   (add_b),
    .sub_i (add_sub),
    .y_o   (add_y)
  );

  assign mul_sum = lo_q[0] ? add_y : hi_q;
  assign step_hi = (op_q == OP_DIV) ? add_y : {1'b0, mul_sum[WIDTH:1]};
  assign step_lo = (op_q == OP_DIV) ? {lo_q[WIDTH-2:0], ~add_y[WIDTH]}
                                    : {mul_sum[0], lo_q[WIDTH-1:1]};

  add_sub_33 u_neg (
    .a_i   ('0),
    .b_i   ({1'b0, step_lo}),
    .sub_i (1'b1),
    .y_o   (neg_y)
  );
  assign unused_neg_msb = neg_y[WIDTH];

  // A negative result may reach -2^31; a positive one must stay below 2^31.
  assign mul_ovf = (|step_hi[WIDTH-1:0]) |
                   (neg_q ? (step_lo[WIDTH-1] & (|step_lo[WIDTH-2:0])) : step_lo[WIDTH-1]);
  assign div_ovf = ~neg_q & step_lo[WIDTH-1];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    exc_d   = exc_q;
    case (state_q)
      RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = DONE;
          if (op_q == OP_MULT) begin
            res_d = neg_q ? neg_y[WIDTH-1:0] : step_lo;
            exc_d = mul_ovf;
          end else if (b_q == '0) begin
            res_d = '0;
            exc_d = 1'b1;
          end else begin
            res_d = neg_q ? neg_y[WIDTH-1:0] : step_lo;
            exc_d = div_ovf;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase
    if (start) begin
      state_d = RUN;
      op_d    = ctrl_MULT ? OP_MULT : OP_DIV;
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      b_d     = mag(data_operandB);
      lo_d    = mag(data_operandA);
      hi_d    = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: the driver queues expected results from a
// plain-arithmetic reference model, a monitor checks every ready strobe.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void model(input logic mul, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic e);
    int     sx, sy, lo;
    longint p;
    sx = x;
    sy = y;
    if (mul) begin
      p  = longint'(sx) * longint'(sy);
      lo = int'(p);
      r  = lo;
      e  = (longint'(lo) != p);
    end else if (sy == 0) begin
      r = 32'h0;
      e = 1'b1;
    end else if (sx == 32'sh80000000 && sy == -1) begin
      r = 32'h80000000;
      e = 1'b1;
    end else begin
      r = sx / sy;
      e = 1'b0;
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ready strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rdy: result 0x%08h with no op outstanding (cycle %0d)",
                 data_result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", data_result, e.res);
        check("exception", {31'd0, data_exception}, {31'd0, e.exc});
        check("rdy_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic start_op(input logic mul, input logic div, input logic [31:0] x,
                          input logic [31:0] y, input bit push);
    logic [31:0] r;
    logic        e;
    @(negedge clock);
    data_operandA = x;
    data_operandB = y;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    if (push) begin
      model(mul, x, y, r, e);
      sb.push_back('{res: r, exc: e, cyc: cyc + 32});
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d results still pending", nm, sb.size());
      sb.delete();
    end
    #1;
    check({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 40)) - 32'd20;
      5:       return {16'h0, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int g;
    logic m, d;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    start_op(1, 0, 32'd7, 32'd6, 1);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    drain("mul_7x6");

    start_op(1, 0, 32'hFFFFFFFB, 32'd3, 1);
    drain("mul_neg5x3");
    start_op(1, 0, 32'h00010000, 32'h00010000, 1);
    drain("mul_ovf");
    start_op(0, 1, 32'hFFFFFFF9, 32'd2, 1);
    drain("div_neg7_2");
    start_op(0, 1, 32'd100, 32'd0, 1);
    drain("div_by_zero");
    start_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 1);
    drain("div_min_neg1");
    start_op(1, 1, 32'd12, 32'd4, 1);
    drain("both_ctrl");

    // 9*9 restarted at its tenth edge by 20/4; only the divide may report.
    start_op(1, 0, 32'd9, 32'd9, 0);
    repeat (9) @(posedge clock);
    start_op(0, 1, 32'd20, 32'd4, 1);
    drain("restart");

    // Asynchronous reset in the middle of a multiply.
    start_op(1, 0, 32'd5, 32'd7, 0);
    repeat (14) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_result", data_result, 32'd0);
    check("async_rst_exc", {31'd0, data_exception}, 32'd0);
    check("async_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    start_op(1, 0, 32'd3, 32'd3, 1);
    drain("after_reset");

    // Random ops; a gap under 33 edges aborts the op, 33 restarts in its DONE cycle.
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      d = ~m | 1'($urandom_range(0, 1));
      if (i == 39)                         g = 36;
      else if ($urandom_range(0, 3) == 0)  g = $urandom_range(1, 32);
      else                                 g = $urandom_range(33, 36);
      start_op(m, d, rnd_operand(), rnd_operand(), g >= 33);
      if (i != 39) repeat (g - 1) @(posedge clock);
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
